// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher: stretches one-clock event ticks into visible LED flashes with a forced dark gap.
// Optional macro LED_PWM_EN dims the LED during ON using the duty input and a free-running PWM counter.
module led_pulse_stretcher #(
    parameter int ON_CYCLES  = 5_000_000,
    parameter int GAP_CYCLES = 5_000_000,
    parameter int MAX_PEND   = 15,
    parameter int PEND_W     = 4,
    parameter int PWM_BITS   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trig,
    input  logic [PWM_BITS-1:0] duty,
    output logic                led,
    output logic                busy,
    output logic [PEND_W-1:0]   pend,
    output logic                drop
);

    localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX = PEND_W'(MAX_PEND);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TIMER_W-1:0]  timer;
    logic [TIMER_W-1:0]  timer_nxt;
    logic [PEND_W-1:0]   pend_nxt;
    logic                drop_nxt;
    logic                pend_inc;
    logic                pend_dec;
    logic                pwm_on;

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // An all-ones duty must be fully lit, which the plain compare cannot express.
    assign pwm_on = (pwm_cnt < duty) || (&duty);
`else
    logic unused_duty;

    assign unused_duty = ^duty;
    assign pwm_on      = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        pend_inc  = 1'b0;
        pend_dec  = 1'b0;

        case (state)
            IDLE: begin
                if (trig) begin
                    state_nxt = ON;
                    timer_nxt = ON_LOAD;
                end
            end
            ON: begin
                pend_inc = trig;
                if (timer == '0) begin
                    // A tick on the final ON cycle still earns its own flash after a gap.
                    if ((pend != '0) || trig) begin
                        state_nxt = GAP;
                        timer_nxt = GAP_LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            GAP: begin
                pend_inc = trig;
                if (timer == '0) begin
                    state_nxt = ON;
                    timer_nxt = ON_LOAD;
                    pend_dec  = (pend != '0);
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    always_comb begin
        pend_nxt = pend;
        drop_nxt = 1'b0;

        if (pend_inc && !pend_dec) begin
            if (pend == PEND_MAX) begin
                drop_nxt = 1'b1;
            end else begin
                pend_nxt = pend + 1'b1;
            end
        end else if (pend_dec && !pend_inc) begin
            pend_nxt = pend - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            pend  <= '0;
            drop  <= 1'b0;
            led   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            pend  <= pend_nxt;
            drop  <= drop_nxt;
            led   <= (state_nxt == ON) && pwm_on;
            busy  <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// tb_led_pulse_stretcher: scenario tasks plus a cycle-level scoreboard for led_pulse_stretcher.
// With LED_PWM_EN defined, a second instance exercises the dimming path.
module tb_led_pulse_stretcher;

    localparam int ON_C  = 4;
    localparam int GAP_C = 3;
    localparam int MAXP  = 2;
    localparam int PW    = 2;
    localparam int PWMB  = 8;

    logic            clk  = 1'b0;
    logic            rst  = 1'b1;
    logic            trig = 1'b0;
    logic [PWMB-1:0] duty = '1;
    logic            led;
    logic            busy;
    logic [PW-1:0]   pend;
    logic            drop;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_pulse_stretcher #(
        .ON_CYCLES (ON_C),
        .GAP_CYCLES(GAP_C),
        .MAX_PEND  (MAXP),
        .PEND_W    (PW),
        .PWM_BITS  (PWMB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .trig(trig),
        .duty(duty),
        .led (led),
        .busy(busy),
        .pend(pend),
        .drop(drop)
    );

    typedef struct packed {
        logic          led;
        logic          busy;
        logic [PW-1:0] pend;
        logic          drop;
    } exp_t;

    typedef enum {M_IDLE, M_ON, M_GAP} mstate_t;

    exp_t    sb_q[$];
    exp_t    sb_e;
    mstate_t m_state = M_IDLE;
    int      m_left  = 0;
    int      m_pend  = 0;

    // Behavioural model: m_left counts the cycles still to spend in the current state.
    task automatic drive(input logic t, input logic r);
        exp_t e;
        bit   inc;
        bit   dec;
        bit   dropv;
        @(negedge clk);
        trig  = t;
        rst   = r;
        dropv = 1'b0;
        if (r) begin
            m_state = M_IDLE;
            m_left  = 0;
            m_pend  = 0;
        end else begin
            inc = 1'b0;
            dec = 1'b0;
            case (m_state)
                M_IDLE: if (t) begin
                    m_state = M_ON;
                    m_left  = ON_C;
                end
                M_ON: begin
                    inc = t;
                    m_left--;
                    if (m_left == 0) begin
                        if (m_pend > 0 || t) begin
                            m_state = M_GAP;
                            m_left  = GAP_C;
                        end else begin
                            m_state = M_IDLE;
                        end
                    end
                end
                M_GAP: begin
                    inc = t;
                    m_left--;
                    if (m_left == 0) begin
                        m_state = M_ON;
                        m_left  = ON_C;
                        dec     = 1'b1;
                    end
                end
                default: m_state = M_IDLE;
            endcase
            if (inc && !dec) begin
                if (m_pend == MAXP) dropv = 1'b1;
                else m_pend++;
            end else if (dec && !inc) begin
                m_pend--;
            end
        end
        e.led  = (m_state == M_ON);
        e.busy = (m_state != M_IDLE);
        e.pend = PW'(m_pend);
        e.drop = dropv;
        sb_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            sb_e = sb_q.pop_front();
            checks++;
            if ({led, busy, pend, drop} !== sb_e) begin
                errors++;
                $display("[TB] FAIL scoreboard t=%0t got led=%b busy=%b pend=%0d drop=%b need led=%b busy=%b pend=%0d drop=%b",
                         $time, led, busy, pend, drop, sb_e.led, sb_e.busy, sb_e.pend, sb_e.drop);
            end
        end
    end

    task automatic test_reset();
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        checks++;
        if ({led, busy, pend, drop} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_state got %b need 00000", {led, busy, pend, drop});
        end
    endtask

    task automatic test_single();
        logic lh[0:24];
        logic bh[0:24];
        int   pend_bad;
        pend_bad = 0;
        drive(1'b0, 1'b1);
        for (int c = 0; c <= 24; c++) begin
            drive(c == 10, 1'b0);
            lh[c] = led;
            bh[c] = busy;
            if (pend !== '0) pend_bad++;
        end
        for (int c = 0; c <= 24; c++) begin
            checks++;
            if (lh[c] !== (c >= 11 && c <= 14) || bh[c] !== (c >= 11 && c <= 14)) begin
                errors++;
                $display("[TB] FAIL single_flash cycle %0d got led=%b busy=%b need %b", c, lh[c], bh[c], (c >= 11 && c <= 14));
            end
        end
        checks++;
        if (pend_bad != 0) begin
            errors++;
            $display("[TB] FAIL single_pend got %0d nonzero cycles need 0", pend_bad);
        end
    endtask

    task automatic test_saturate();
        logic          lh[0:32];
        logic          bh[0:32];
        logic          dh[0:32];
        logic [PW-1:0] ph[0:32];
        int            drops;
        bit            on_exp;
        drops = 0;
        drive(1'b0, 1'b1);
        for (int c = 0; c <= 32; c++) begin
            drive(c == 10 || c == 12 || c == 13 || c == 14, 1'b0);
            lh[c] = led;
            bh[c] = busy;
            dh[c] = drop;
            ph[c] = pend;
            if (drop === 1'b1) drops++;
        end
        for (int c = 0; c <= 32; c++) begin
            on_exp = (c >= 11 && c <= 14) || (c >= 18 && c <= 21) || (c >= 25 && c <= 28);
            checks++;
            if (lh[c] !== on_exp || bh[c] !== (c >= 11 && c <= 28)) begin
                errors++;
                $display("[TB] FAIL saturate_led cycle %0d got led=%b busy=%b need led=%b", c, lh[c], bh[c], on_exp);
            end
        end
        checks++;
        if (ph[13] !== 2'd1 || ph[14] !== 2'd2 || ph[15] !== 2'd2 || ph[18] !== 2'd1 || ph[25] !== 2'd0) begin
            errors++;
            $display("[TB] FAIL saturate_pend got %0d,%0d,%0d,%0d,%0d need 1,2,2,1,0", ph[13], ph[14], ph[15], ph[18], ph[25]);
        end
        checks++;
        if (dh[15] !== 1'b1 || drops != 1) begin
            errors++;
            $display("[TB] FAIL saturate_drop got drop@15=%b count=%0d need 1 and 1", dh[15], drops);
        end
    endtask

    task automatic test_gap_boundary();
        logic          lh[0:30];
        logic [PW-1:0] ph[0:30];
        int            drops;
        bit            on_exp;
        drops = 0;
        drive(1'b0, 1'b1);
        for (int c = 0; c <= 30; c++) begin
            drive(c == 10 || c == 12 || c == 17, 1'b0);
            lh[c] = led;
            ph[c] = pend;
            if (drop === 1'b1) drops++;
            if (c == 29) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL gap_boundary_idle got busy=%b need 0", busy);
                end
            end
        end
        for (int c = 0; c <= 30; c++) begin
            on_exp = (c >= 11 && c <= 14) || (c >= 18 && c <= 21) || (c >= 25 && c <= 28);
            checks++;
            if (lh[c] !== on_exp) begin
                errors++;
                $display("[TB] FAIL gap_boundary_led cycle %0d got %b need %b", c, lh[c], on_exp);
            end
        end
        checks++;
        if (ph[17] !== 2'd1 || ph[18] !== 2'd1 || ph[25] !== 2'd0 || drops != 0) begin
            errors++;
            $display("[TB] FAIL gap_boundary_pend got %0d,%0d,%0d drops=%0d need 1,1,0 drops=0", ph[17], ph[18], ph[25], drops);
        end
    endtask

    task automatic test_reset_mid_flash();
        int lit;
        lit = 0;
        drive(1'b0, 1'b1);
        for (int c = 0; c <= 30; c++) begin
            drive(c == 10 || c == 12 || c == 13 || c == 14, c == 14);
            if (c == 14) begin
                checks++;
                if (led !== 1'b1 || pend !== 2'd2) begin
                    errors++;
                    $display("[TB] FAIL reset_mid_pre got led=%b pend=%0d need 1 and 2", led, pend);
                end
            end
            if (c == 15) begin
                checks++;
                if ({led, busy, pend, drop} !== 5'b0) begin
                    errors++;
                    $display("[TB] FAIL reset_mid_post got %b need 00000", {led, busy, pend, drop});
                end
            end
            if (c >= 15 && led === 1'b1) lit++;
        end
        checks++;
        if (lit != 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_noflash got %0d lit cycles need 0", lit);
        end
    endtask

    task automatic test_last_on_trig();
        logic          lh[0:26];
        logic          bh[0:26];
        logic [PW-1:0] ph[0:26];
        bit            on_exp;
        drive(1'b0, 1'b1);
        for (int c = 0; c <= 26; c++) begin
            drive(c == 10 || c == 14, 1'b0);
            lh[c] = led;
            bh[c] = busy;
            ph[c] = pend;
        end
        for (int c = 0; c <= 26; c++) begin
            on_exp = (c >= 11 && c <= 14) || (c >= 18 && c <= 21);
            checks++;
            if (lh[c] !== on_exp || bh[c] !== (c >= 11 && c <= 21)) begin
                errors++;
                $display("[TB] FAIL last_on_trig cycle %0d got led=%b busy=%b need led=%b", c, lh[c], bh[c], on_exp);
            end
        end
        checks++;
        if (ph[15] !== 2'd1 || ph[18] !== 2'd0) begin
            errors++;
            $display("[TB] FAIL last_on_trig_pend got %0d,%0d need 1,0", ph[15], ph[18]);
        end
    endtask

    task automatic test_back_to_back();
        int on_run;
        int gap_run;
        on_run  = 0;
        gap_run = 0;
        drive(1'b0, 1'b1);
        for (int c = 0; c < 340; c++) begin
            drive((c < 300) && ($urandom_range(0, 2) == 0), 1'b0);
            if (led === 1'b1) begin
                on_run++;
            end else if (on_run > 0) begin
                checks++;
                if (on_run != ON_C) begin
                    errors++;
                    $display("[TB] FAIL b2b_on_len got %0d need %0d", on_run, ON_C);
                end
                on_run = 0;
            end
            if (busy === 1'b1 && led === 1'b0) begin
                gap_run++;
            end else if (gap_run > 0) begin
                checks++;
                if (gap_run != GAP_C) begin
                    errors++;
                    $display("[TB] FAIL b2b_gap_len got %0d need %0d", gap_run, GAP_C);
                end
                gap_run = 0;
            end
        end
        checks++;
        if (busy !== 1'b0 || pend !== '0) begin
            errors++;
            $display("[TB] FAIL b2b_drain got busy=%b pend=%0d need 0 and 0", busy, pend);
        end
    endtask

`ifdef LED_PWM_EN
    logic       rst2  = 1'b1;
    logic       trig2 = 1'b0;
    logic [1:0] duty2 = 2'd0;
    logic       led2;
    logic       busy2;
    logic [1:0] pend2;
    logic       drop2;

    led_pulse_stretcher #(
        .ON_CYCLES (16),
        .GAP_CYCLES(3),
        .MAX_PEND  (2),
        .PEND_W    (2),
        .PWM_BITS  (2)
    ) dut_pwm (
        .clk (clk),
        .rst (rst2),
        .trig(trig2),
        .duty(duty2),
        .led (led2),
        .busy(busy2),
        .pend(pend2),
        .drop(drop2)
    );

    task automatic test_pwm();
        int dv[3];
        int el[3];
        int lc;
        int bc;
        dv[0] = 1; dv[1] = 3; dv[2] = 0;
        el[0] = 4; el[1] = 16; el[2] = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            duty2 = 2'(dv[i]);
            rst2  = 1'b1;
            trig2 = 1'b0;
            @(negedge clk);
            rst2  = 1'b0;
            trig2 = 1'b1;
            @(negedge clk);
            trig2 = 1'b0;
            lc = 0;
            bc = 0;
            for (int j = 0; j < 20; j++) begin
                if (led2 === 1'b1) lc++;
                if (busy2 === 1'b1) bc++;
                @(negedge clk);
            end
            checks++;
            if (lc != el[i] || bc != 16) begin
                errors++;
                $display("[TB] FAIL pwm_duty%0d got lit=%0d busy=%0d need lit=%0d busy=16", dv[i], lc, bc, el[i]);
            end
        end
    endtask
`endif

    initial begin
        $display("[TB] starting led_pulse_stretcher bench");
        test_reset();
        test_single();
        test_saturate();
        test_gap_boundary();
        test_reset_mid_flash();
        test_last_on_trig();
        test_back_to_back();
`ifdef LED_PWM_EN
        test_pwm();
`endif
        drive(1'b0, 1'b0);
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
